// File: rtl/seg7_hex_bank.sv
// seg7_hex_bank
//
// Multi-digit hex display driver for 7-segment displays.
// - Captures a packed NUM_DIGITS x 4-bit value when load is high.
// - Drives NUM_DIGITS displays from registered outputs.
// - Supports a per-digit enable, leading-zero blanking, and per-digit
//   blinking timed by an internal divider.
//
// Parameters:
//   NUM_DIGITS  number of hex digits (1..8); digit 0 is least significant
//   BLINK_DIV   clock cycles per blink half-period (>= 2)
//   ACTIVE_LOW  1: segment on = 0; 0: segment on = 1
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset_n      synchronous active-low reset
//   val          packed digit values, digit i = val[4i+3:4i]
//   load         capture val into the value register this cycle
//   digit_en     bit i = 0 forces digit i blank
//   blink_mask   bit i = 1 makes digit i blink
//   lz_blank     1 enables leading-zero blanking
//   display      packed segments, digit i = display[7i+6:7i], order gfedcba
//   blink_phase  current blink phase (1 = visible)
module seg7_hex_bank #(
   parameter int NUM_DIGITS = 6,
   parameter int BLINK_DIV  = 25_000_000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [4*NUM_DIGITS-1:0] val,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic                    lz_blank,
   output logic [7*NUM_DIGITS-1:0] display,
   output logic                    blink_phase
);

   localparam int CW = $clog2(BLINK_DIV);

   // Glyphs are stored in active-low form.
   // XOR with this mask converts them to the configured polarity.
   localparam logic [6:0] POL_MASK = (ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
   localparam logic [6:0] BLANK    = 7'h7F ^ POL_MASK;

   logic [4*NUM_DIGITS-1:0] value_reg;
   logic [CW-1:0]           cnt_reg;
   logic                    phase_reg;
   logic [7*NUM_DIGITS-1:0] display_reg;
   logic [7*NUM_DIGITS-1:0] display_next;

   function automatic logic [6:0] decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg ^ POL_MASK;
   endfunction

   // Per-digit segment selection.
   // The leading-zero test looks only at the value register.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         logic [3:0] nib;
         logic       lead_zero;
         logic       blank;

         assign nib = value_reg[4*gi +: 4];

         if (gi == 0) begin : g_lsd
            // Digit 0 always shows something, so a value of 0 displays "0".
            assign lead_zero = 1'b0;
         end else begin : g_upper
            // Digit gi is a leading zero if every digit from the top down to gi is 0.
            assign lead_zero = (value_reg[4*NUM_DIGITS-1:4*gi] == '0);
         end

         assign blank = ~digit_en[gi]
                      | (blink_mask[gi] & ~phase_reg)
                      | (lz_blank & lead_zero);

         assign display_next[7*gi +: 7] = blank ? BLANK : decode(nib);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         value_reg   <= '0;
         cnt_reg     <= '0;
         phase_reg   <= 1'b1;
         display_reg <= {NUM_DIGITS{BLANK}};
      end else begin
         display_reg <= display_next;

         if (load) begin
            // A fresh value restarts the blink cycle in the visible phase.
            value_reg <= val;
            cnt_reg   <= '0;
            phase_reg <= 1'b1;
         end else if (cnt_reg == CW'(BLINK_DIV - 1)) begin
            cnt_reg   <= '0;
            phase_reg <= ~phase_reg;
         end else begin
            cnt_reg   <= cnt_reg + CW'(1);
         end
      end
   end

   assign display     = display_reg;
   assign blink_phase = phase_reg;

endmodule

// File: tb/tb_seg7_hex_bank.sv
module tb_seg7_hex_bank;

   localparam int ND = 6;
   localparam int BD = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [4*ND-1:0] val;
   logic          load;
   logic [ND-1:0] digit_en;
   logic [ND-1:0] blink_mask;
   logic          lz_blank;
   logic [7*ND-1:0] display_a;
   logic [7*ND-1:0] display_b;
   logic          phase_a;
   logic          phase_b;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   // m_ticks counts edges since the last load or reset.
   logic [4*ND-1:0] m_val;
   int              m_ticks;
   logic [6:0]      glyph [16];

   always #5 clk = ~clk;

   seg7_hex_bank #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .ACTIVE_LOW(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .val(val), .load(load),
      .digit_en(digit_en), .blink_mask(blink_mask), .lz_blank(lz_blank),
      .display(display_a), .blink_phase(phase_a)
   );

   seg7_hex_bank #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .ACTIVE_LOW(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .val(val), .load(load),
      .digit_en(digit_en), .blink_mask(blink_mask), .lz_blank(lz_blank),
      .display(display_b), .blink_phase(phase_b)
   );

   typedef struct {
      string           name;
      logic [4*ND-1:0] v;
      logic [ND-1:0]   en;
      logic            lz;
      logic [7*ND-1:0] exp;
   } vec_t;

   vec_t vecs [6];

   function automatic logic [7*ND-1:0] p6(input logic [6:0] d5, input logic [6:0] d4,
                                          input logic [6:0] d3, input logic [6:0] d2,
                                          input logic [6:0] d1, input logic [6:0] d0);
      return {d5, d4, d3, d2, d1, d0};
   endfunction

   function automatic logic model_phase();
      return ((m_ticks / BD) % 2) == 0;
   endfunction

   // Expected active-low display from the model state and the live controls.
   function automatic logic [7*ND-1:0] model_disp();
      logic [7*ND-1:0] d;
      d = '0;
      for (int i = 0; i < ND; i++) begin
         logic blank;
         blank = !digit_en[i]
               || (blink_mask[i] && !model_phase())
               || (lz_blank && i != 0 && (m_val >> (4*i)) == 0);
         d[7*i +: 7] = blank ? 7'h7F : glyph[m_val[4*i +: 4]];
      end
      return d;
   endfunction

   task automatic check(input string name, input logic [7*ND-1:0] act, input logic [7*ND-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Advance one clock and compare both DUTs against the model.
   task automatic step(input string tag);
      logic [7*ND-1:0] exp;
      logic            rst;
      logic            ld;
      logic [4*ND-1:0] v;
      rst = !reset_n;
      ld  = load;
      v   = val;
      exp = rst ? {ND{7'h7F}} : model_disp();
      @(posedge clk);
      if (rst) begin
         m_val = '0;
         m_ticks = 0;
      end else if (ld) begin
         m_val = v;
         m_ticks = 0;
      end else begin
         m_ticks++;
      end
      #1;
      check({tag, " display"}, display_a, exp);
      check({tag, " display_inv"}, display_b, ~exp);
      check({tag, " phase"}, {{(7*ND-2){1'b0}}, phase_b, phase_a},
            {{(7*ND-2){1'b0}}, model_phase(), model_phase()});
   endtask

   initial begin
      glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
      glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
      glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
      glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;

      vecs[0] = '{"dec012345", 24'h012345, 6'h3F, 1'b0, p6(7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12)};
      vecs[1] = '{"decABCDEF", 24'hABCDEF, 6'h3F, 1'b0, p6(7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E)};
      vecs[2] = '{"lz000A05",  24'h000A05, 6'h3F, 1'b1, p6(7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12)};
      vecs[3] = '{"lz000000",  24'h000000, 6'h3F, 1'b1, p6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40)};
      vecs[4] = '{"en101010",  24'h012345, 6'h2A, 1'b0, p6(7'h40, 7'h7F, 7'h24, 7'h7F, 7'h19, 7'h7F)};
      vecs[5] = '{"lzoff0",    24'h000000, 6'h3F, 1'b0, p6(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40)};

      m_val      = '0;
      m_ticks    = 0;
      reset_n    = 1'b0;
      val        = 24'hABCDEF;
      load       = 1'b1;
      digit_en   = 6'h3F;
      blink_mask = '0;
      lz_blank   = 1'b0;

      // Reset wins over load.
      repeat (3) step("reset");

      reset_n = 1'b1;
      load    = 1'b0;
      step("release");
      check("release_zeros", display_a, {ND{7'h40}});

      // Table vectors: load, one cycle of latency, then a val change without load.
      for (int k = 0; k < 6; k++) begin
         val        = vecs[k].v;
         digit_en   = vecs[k].en;
         lz_blank   = vecs[k].lz;
         blink_mask = '0;
         load       = 1'b1;
         step(vecs[k].name);
         load = 1'b0;
         step(vecs[k].name);
         check({vecs[k].name, " tbl"}, display_a, vecs[k].exp);
         check({vecs[k].name, " tbl_inv"}, display_b, ~vecs[k].exp);
         val = $urandom;
         step(vecs[k].name);
         check({vecs[k].name, " hold"}, display_a, vecs[k].exp);
      end

      // Blink on digit 0: visible for 4 cycles, then blank for 4 cycles.
      digit_en   = 6'h3F;
      lz_blank   = 1'b0;
      blink_mask = 6'b000001;
      val        = 24'h00000F;
      load       = 1'b1;
      step("blink_load");
      load = 1'b0;
      for (int k = 0; k < 16; k++) begin
         step("blink");
         check("blink_d0", {35'b0, display_a[6:0]},
               {35'b0, (((k / 4) % 2) == 0) ? 7'h0E : 7'h7F});
         check("blink_d1", {35'b0, display_a[13:7]}, {35'b0, 7'h40});
      end

      // Load during the blank phase.
      begin
         int budget;
         budget = 0;
         while (!(m_ticks % (2*BD) == BD + 1) && budget < 20) begin
            step("seek_blank");
            budget++;
         end
         if (budget >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL seek_blank: budget %0d expired, wanted 20 max", budget);
         end
      end
      load = 1'b1;
      step("load_blank");
      check("load_blank_phase", {41'b0, phase_a}, {41'b0, 1'b1});
      load = 1'b0;
      step("load_blank_vis");
      check("load_blank_vis", {35'b0, display_a[6:0]}, {35'b0, 7'h0E});

      // Load on the wrap cycle (counter at BLINK_DIV-1).
      begin
         int budget;
         budget = 0;
         while (!(m_ticks % BD == BD - 1) && budget < 20) begin
            step("seek_wrap");
            budget++;
         end
         if (budget >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL seek_wrap: budget %0d expired, wanted 20 max", budget);
         end
      end
      load = 1'b1;
      step("load_wrap");
      check("load_wrap_phase", {41'b0, phase_a}, {41'b0, 1'b1});
      load = 1'b0;
      step("load_wrap_vis");
      check("load_wrap_vis", {35'b0, display_a[6:0]}, {35'b0, 7'h0E});

      // Randomized stimulus against the model.
      for (int k = 0; k < 400; k++) begin
         reset_n    = ($urandom_range(0, 39) != 0);
         load       = ($urandom_range(0, 5) == 0);
         val        = $urandom;
         digit_en   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h3F;
         blink_mask = 6'($urandom);
         lz_blank   = 1'($urandom);
         if ($urandom_range(0, 3) == 0) val[23:12] = '0;
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
